// File: rtl/bus_decode_waitgen_pkg.sv
// Shared types and config-register offsets for the bus decoder / wait-state generator.
package bus_decode_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM,
    REG_BRAM,
    REG_PERIPH,
    REG_RAM
  } region_t;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_WAIT,
    WS_HOLD
  } wstate_t;

  localparam logic [3:0] CFG_OFS_ROM  = 4'd8;
  localparam logic [3:0] CFG_OFS_BRAM = 4'd9;
  localparam logic [3:0] CFG_OFS_RAM  = 4'd10;

endpackage

// File: rtl/bus_decode_waitgen_if.sv
// CPU-side bus bundle: address/strobes in, chip selects, wait and config read data out.
interface bus_decode_waitgen_if #(
  parameter int ADDR_W     = 22,
  parameter int PERIPH_W   = 3,
  parameter int RAM_BANK_W = 3
);
  localparam int NUM_PERIPH = 2 ** PERIPH_W;
  localparam int NUM_RAM    = 2 ** RAM_BANK_W;

  logic [ADDR_W-1:0]     address;
  logic                  mem_io;
  logic                  rd;
  logic                  wr;
  logic [7:0]            data_in;
  logic [7:0]            data_out;
  logic                  data_oe;
  logic                  pin_wait;
  logic                  rom_cs_n;
  logic                  bram_cs_n;
  logic [NUM_PERIPH-1:0] periph_cs_n;
  logic [NUM_RAM-1:0]    ram_cs_n;
  logic                  bus_err;

  modport master (
    output address, mem_io, rd, wr, data_in,
    input  data_out, data_oe, pin_wait, rom_cs_n, bram_cs_n, periph_cs_n, ram_cs_n, bus_err
  );

  modport slave (
    input  address, mem_io, rd, wr, data_in,
    output data_out, data_oe, pin_wait, rom_cs_n, bram_cs_n, periph_cs_n, ram_cs_n, bus_err
  );
endinterface

// File: rtl/bus_decode_waitgen_ws_counter.sv
// Wait-state down counter: loadable, decrements on request, flags the last wait cycle.
module ws_counter
  import bus_decode_pkg::*;
#(
  parameter int WS_W = 4
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  input  logic            dec,
  output logic            term
);

  logic [WS_W-1:0] cnt_r;

  // counter register: load wins over decrement, never wraps below zero
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt_r <= {WS_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {WS_W{1'b0}})) begin
      cnt_r <= cnt_r - WS_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = (cnt_r == WS_W'(1));

endmodule

// File: rtl/bus_decode_waitgen.sv
// Chip-select decode plus per-region programmable wait-state generator; the wait-state
// table is a register file on peripheral channel CFG_CH.
module bus_decode_waitgen
  import bus_decode_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int PERIPH_W    = 3,
  parameter int RAM_BANK_W  = 3,
  parameter int WS_W        = 4,
  parameter int CFG_CH      = (2 ** PERIPH_W) - 1,
  parameter int ROM_WS_RST  = 2,
  parameter int BRAM_WS_RST = 1,
  parameter int RAM_WS_RST  = 1,
  parameter int PER_WS_RST  = 3
) (
  input logic                 clk,
  input logic                 arst,
  bus_decode_waitgen_if.slave bus
);

  localparam int NUM_PERIPH = 2 ** PERIPH_W;
  localparam int NUM_RAM    = 2 ** RAM_BANK_W;

  logic                  real_s, hi_s, per_s, rom_s, bram_s, cfg_live_s;
  logic [PERIPH_W-1:0]   sel_s;
  logic [RAM_BANK_W-1:0] bank_s;
  logic [3:0]            ofs_s;
  logic [NUM_PERIPH-1:0] periph_cs_s;
  logic [NUM_RAM-1:0]    ram_cs_s;
  region_t               region_s;
  logic [WS_W-1:0]       ws_sel_s, rd_ws_s;
  logic [WS_W-1:0]       per_ws_r [NUM_PERIPH];
  logic [WS_W-1:0]       rom_ws_r, bram_ws_r, ram_ws_r;
  logic                  strobe_s, start_s, strobe_q_r, bus_err_r;
  wstate_t               state_r, state_nx_s;
  logic                  load_s, dec_s, wait_s, term_s;
  logic                  cfg_hit_r, cfg_hit_s, cfg_we_s;
  logic [3:0]            cfg_ofs_r, cfg_ofs_s;
  logic                  unused_data_s;

  assign real_s     = (bus.address[ADDR_W-1:16] == {(ADDR_W-16){1'b0}});
  assign hi_s       = &bus.address[14:7];
  assign per_s      = hi_s & bus.address[15] & bus.mem_io;
  assign rom_s      = bus.mem_io & real_s & ~bus.address[15];
  assign bram_s     = bus.mem_io & real_s & bus.address[15] & ~hi_s;
  assign sel_s      = bus.address[4+PERIPH_W-1:4];
  assign bank_s     = bus.address[ADDR_W-1 -: RAM_BANK_W];
  assign ofs_s      = bus.address[3:0];
  assign cfg_live_s = per_s & (sel_s == PERIPH_W'(CFG_CH));
  assign unused_data_s = ^bus.data_in[7:WS_W];

  // one-hot active-low peripheral and ext-RAM bank selects
  always_comb begin
    periph_cs_s = {NUM_PERIPH{1'b1}};
    ram_cs_s    = {NUM_RAM{1'b1}};
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (per_s && (sel_s == PERIPH_W'(k))) periph_cs_s[k] = 1'b0;
      else                                  periph_cs_s[k] = 1'b1;
    end
    for (int b = 0; b < NUM_RAM; b++) begin
      if (!bus.mem_io && (bank_s == RAM_BANK_W'(b))) ram_cs_s[b] = 1'b0;
      else                                           ram_cs_s[b] = 1'b1;
    end
  end

  // region classification and its wait-state count
  always_comb begin
    if (!bus.mem_io)  region_s = REG_RAM;
    else if (rom_s)   region_s = REG_ROM;
    else if (bram_s)  region_s = REG_BRAM;
    else if (per_s)   region_s = REG_PERIPH;
    else              region_s = REG_NONE;
    case (region_s)
      REG_ROM:    ws_sel_s = rom_ws_r;
      REG_BRAM:   ws_sel_s = bram_ws_r;
      REG_PERIPH: ws_sel_s = per_ws_r[sel_s];
      REG_RAM:    ws_sel_s = ram_ws_r;
      default:    ws_sel_s = {WS_W{1'b0}};
    endcase
  end

  assign strobe_s = ~bus.rd | ~bus.wr;
  assign start_s  = strobe_s & ~strobe_q_r;

  // wait FSM next state; pin_wait covers the start cycle plus every WAIT cycle
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    dec_s      = 1'b0;
    wait_s     = 1'b0;
    case (state_r)
      WS_IDLE: begin
        if (start_s) begin
          wait_s = (ws_sel_s != {WS_W{1'b0}});
          if (ws_sel_s > WS_W'(1)) begin
            state_nx_s = WS_WAIT;
            load_s     = 1'b1;
          end else begin
            state_nx_s = WS_HOLD;
          end
        end else begin
          state_nx_s = WS_IDLE;
        end
      end
      WS_WAIT: begin
        dec_s  = 1'b1;
        wait_s = 1'b1;
        if (!strobe_s)   state_nx_s = WS_IDLE;
        else if (term_s) state_nx_s = WS_HOLD;
        else             state_nx_s = WS_WAIT;
      end
      WS_HOLD: begin
        if (!strobe_s) state_nx_s = WS_IDLE;
        else           state_nx_s = WS_HOLD;
      end
      default: state_nx_s = WS_IDLE;
    endcase
  end

  ws_counter #(.WS_W(WS_W)) u_ws_counter (
    .clk      (clk),
    .arst     (arst),
    .load     (load_s),
    .load_val (ws_sel_s - WS_W'(1)),
    .dec      (dec_s),
    .term     (term_s)
  );

  // FSM, strobe edge detector, sticky bus error, config target latched at start
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_r    <= WS_IDLE;
      strobe_q_r <= 1'b0;
      bus_err_r  <= 1'b0;
      cfg_hit_r  <= 1'b0;
      cfg_ofs_r  <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      strobe_q_r <= strobe_s;
      if (!bus.rd && !bus.wr) bus_err_r <= 1'b1;
      else                    bus_err_r <= bus_err_r;
      if ((state_r == WS_IDLE) && start_s) begin
        cfg_hit_r <= cfg_live_s;
        cfg_ofs_r <= ofs_s;
      end else begin
        cfg_hit_r <= cfg_hit_r;
        cfg_ofs_r <= cfg_ofs_r;
      end
    end
  end

  // a zero/one wait-state write enters HOLD on its start edge, before the latch is loaded
  assign cfg_hit_s = (state_r == WS_IDLE) ? cfg_live_s : cfg_hit_r;
  assign cfg_ofs_s = (state_r == WS_IDLE) ? ofs_s : cfg_ofs_r;
  assign cfg_we_s  = (state_nx_s == WS_HOLD) && (state_r != WS_HOLD) &&
                     !bus.wr && bus.rd && cfg_hit_s;

  // wait-state register file
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int k = 0; k < NUM_PERIPH; k++) per_ws_r[k] <= WS_W'(PER_WS_RST);
      rom_ws_r  <= WS_W'(ROM_WS_RST);
      bram_ws_r <= WS_W'(BRAM_WS_RST);
      ram_ws_r  <= WS_W'(RAM_WS_RST);
    end else if (cfg_we_s) begin
      if (cfg_ofs_s[3:PERIPH_W] == {(4-PERIPH_W){1'b0}})
        per_ws_r[cfg_ofs_s[PERIPH_W-1:0]] <= bus.data_in[WS_W-1:0];
      else if (cfg_ofs_s == CFG_OFS_ROM)  rom_ws_r  <= bus.data_in[WS_W-1:0];
      else if (cfg_ofs_s == CFG_OFS_BRAM) bram_ws_r <= bus.data_in[WS_W-1:0];
      else if (cfg_ofs_s == CFG_OFS_RAM)  ram_ws_r  <= bus.data_in[WS_W-1:0];
      else                                rom_ws_r  <= rom_ws_r;
    end else begin
      rom_ws_r <= rom_ws_r;
    end
  end

  // config read mux on the live offset; reserved offsets read zero
  always_comb begin
    rd_ws_s = {WS_W{1'b0}};
    if (ofs_s[3:PERIPH_W] == {(4-PERIPH_W){1'b0}}) rd_ws_s = per_ws_r[ofs_s[PERIPH_W-1:0]];
    else if (ofs_s == CFG_OFS_ROM)                 rd_ws_s = rom_ws_r;
    else if (ofs_s == CFG_OFS_BRAM)                rd_ws_s = bram_ws_r;
    else if (ofs_s == CFG_OFS_RAM)                 rd_ws_s = ram_ws_r;
    else                                           rd_ws_s = {WS_W{1'b0}};
  end

  assign bus.rom_cs_n    = ~rom_s;
  assign bus.bram_cs_n   = ~bram_s;
  assign bus.periph_cs_n = periph_cs_s;
  assign bus.ram_cs_n    = ram_cs_s;
  assign bus.data_out    = {{(8-WS_W){1'b0}}, rd_ws_s};
  assign bus.data_oe     = arst & cfg_live_s & ~bus.rd & bus.wr;
  assign bus.pin_wait    = arst & wait_s;
  assign bus.bus_err     = bus_err_r;

endmodule

// File: tb/tb_bus_decode_waitgen.sv
// Directed bench for bus_decode_waitgen: decode and config-read tables plus wait-timing sequences.
module tb_bus_decode_waitgen;

  logic clk = 1'b0;
  logic arst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bus_decode_waitgen_if bus_if ();

  bus_decode_waitgen dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] addr;
    logic        mio;
    logic [17:0] exp;   // {rom_cs_n, bram_cs_n, periph_cs_n[7:0], ram_cs_n[7:0]}
  } dec_vec_t;

  typedef struct {
    logic [3:0] ofs;
    logic [7:0] exp;
  } cfg_vec_t;

  dec_vec_t dec_tab [12];
  cfg_vec_t cfg_tab [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] cs_snap();
    return {bus_if.rom_cs_n, bus_if.bram_cs_n, bus_if.periph_cs_n, bus_if.ram_cs_n};
  endfunction

  // mode 0 = read, 1 = write, 2 = rd and wr both low; strobe held for len cycles
  task automatic access(input logic [21:0] a, input logic mio, input int mode,
                        input logic [7:0] d, input int len,
                        output int wcnt, output logic [7:0] rdata, output logic oe,
                        output logic [17:0] cs, output logic idle_wait);
    wcnt = 0;
    @(posedge clk); #2;
    bus_if.address = a;
    bus_if.mem_io  = mio;
    bus_if.data_in = d;
    bus_if.rd = (mode == 1) ? 1'b1 : 1'b0;
    bus_if.wr = (mode == 0) ? 1'b1 : 1'b0;
    #1;
    cs = cs_snap();
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        @(posedge clk); #3;
      end
      if (bus_if.pin_wait) begin
        if (wcnt != i) wcnt = -100;
        else           wcnt++;
      end
      rdata = bus_if.data_out;
      oe    = bus_if.data_oe;
    end
    @(posedge clk); #2;
    bus_if.rd = 1'b1;
    bus_if.wr = 1'b1;
    @(posedge clk); #3;
    idle_wait = bus_if.pin_wait;
  endtask

  int         wc;
  logic [7:0] rdv;
  logic       oev, iw;
  logic [17:0] csv;

  initial begin
    dec_tab[0]  = '{22'h000100, 1'b1, {1'b0, 1'b1, 8'hFF, 8'hFF}};
    dec_tab[1]  = '{22'h008000, 1'b1, {1'b1, 1'b0, 8'hFF, 8'hFF}};
    dec_tab[2]  = '{22'h00FF80, 1'b1, {1'b1, 1'b1, 8'hFE, 8'hFF}};
    dec_tab[3]  = '{22'h00FFA0, 1'b1, {1'b1, 1'b1, 8'hFB, 8'hFF}};
    dec_tab[4]  = '{22'h00FFF8, 1'b1, {1'b1, 1'b1, 8'h7F, 8'hFF}};
    dec_tab[5]  = '{22'h00FF00, 1'b1, {1'b1, 1'b0, 8'hFF, 8'hFF}};
    dec_tab[6]  = '{22'h010000, 1'b1, {1'b1, 1'b1, 8'hFF, 8'hFF}};
    dec_tab[7]  = '{22'h1FFF80, 1'b1, {1'b1, 1'b1, 8'hFE, 8'hFF}};
    dec_tab[8]  = '{22'h2A0000, 1'b0, {1'b1, 1'b1, 8'hFF, 8'hDF}};
    dec_tab[9]  = '{22'h3FFFFF, 1'b0, {1'b1, 1'b1, 8'hFF, 8'h7F}};
    dec_tab[10] = '{22'h00FFF0, 1'b0, {1'b1, 1'b1, 8'hFF, 8'hFE}};
    dec_tab[11] = '{22'h007FFF, 1'b1, {1'b0, 1'b1, 8'hFF, 8'hFF}};

    cfg_tab[0] = '{4'd0,  8'h03};
    cfg_tab[1] = '{4'd7,  8'h03};
    cfg_tab[2] = '{4'd8,  8'h02};
    cfg_tab[3] = '{4'd9,  8'h01};
    cfg_tab[4] = '{4'd10, 8'h01};
    cfg_tab[5] = '{4'd11, 8'h00};
    cfg_tab[6] = '{4'd15, 8'h00};

    bus_if.address = 22'h000100;
    bus_if.mem_io  = 1'b1;
    bus_if.rd      = 1'b1;
    bus_if.wr      = 1'b1;
    bus_if.data_in = 8'h00;

    repeat (3) @(posedge clk);
    #3;
    chk("reset_pin_wait", {31'd0, bus_if.pin_wait}, 32'd0);
    chk("reset_bus_err",  {31'd0, bus_if.bus_err},  32'd0);
    chk("reset_data_oe",  {31'd0, bus_if.data_oe},  32'd0);
    arst = 1'b1;

    // static decode with strobes idle
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      bus_if.address = dec_tab[i].addr;
      bus_if.mem_io  = dec_tab[i].mio;
      #1;
      chk($sformatf("decode_%0d", i), {14'd0, cs_snap()}, {14'd0, dec_tab[i].exp});
      chk($sformatf("decode_wait_%0d", i), {31'd0, bus_if.pin_wait}, 32'd0);
    end

    // ROM read after reset: 2 wait cycles
    access(22'h000100, 1'b1, 0, 8'h00, 6, wc, rdv, oev, csv, iw);
    chk("rom_rst_cs", {31'd0, csv[17]}, 32'd0);
    chk("rom_rst_wait", wc, 32'd2);

    // reset contents of the wait-state table, each config access waits 3
    for (int i = 0; i < 7; i++) begin
      access(22'h00FFF0 | {18'd0, cfg_tab[i].ofs}, 1'b1, 0, 8'h00, 5, wc, rdv, oev, csv, iw);
      chk($sformatf("cfg_rd_%0d", cfg_tab[i].ofs), {24'd0, rdv}, {24'd0, cfg_tab[i].exp});
      chk($sformatf("cfg_rd_oe_%0d", cfg_tab[i].ofs), {31'd0, oev}, 32'd1);
      chk($sformatf("cfg_rd_wait_%0d", cfg_tab[i].ofs), wc, 32'd3);
    end

    // ROM ws -> 5
    access(22'h00FFF8, 1'b1, 1, 8'h05, 6, wc, rdv, oev, csv, iw);
    chk("cfg_wr_wait", wc, 32'd3);
    chk("cfg_wr_oe", {31'd0, oev}, 32'd0);
    access(22'h00FFF8, 1'b1, 0, 8'h00, 6, wc, rdv, oev, csv, iw);
    chk("rom_ws_readback", {24'd0, rdv}, 32'h05);
    access(22'h000100, 1'b1, 0, 8'h00, 8, wc, rdv, oev, csv, iw);
    chk("rom_ws5_wait", wc, 32'd5);

    // BIOS RAM ws -> 0
    access(22'h00FFF9, 1'b1, 1, 8'h00, 6, wc, rdv, oev, csv, iw);
    access(22'h008000, 1'b1, 0, 8'h00, 4, wc, rdv, oev, csv, iw);
    chk("bram_cs", {31'd0, csv[16]}, 32'd0);
    chk("bram_ws0_wait", wc, 32'd0);

    // ext RAM bank 5, reset ws 1
    access(22'h2A0000, 1'b0, 0, 8'h00, 4, wc, rdv, oev, csv, iw);
    chk("ram5_cs", {24'd0, csv[7:0]}, 32'hDF);
    chk("ram5_wait", wc, 32'd1);

    // abort ROM (ws 5) after 2 cycles; next access must restart cleanly
    access(22'h000100, 1'b1, 0, 8'h00, 2, wc, rdv, oev, csv, iw);
    chk("abort_wait", wc, 32'd2);
    chk("abort_idle_wait", {31'd0, iw}, 32'd0);
    access(22'h000100, 1'b1, 0, 8'h00, 8, wc, rdv, oev, csv, iw);
    chk("after_abort_wait", wc, 32'd5);

    // config write aborted while in WAIT leaves the register alone
    access(22'h00FFF0, 1'b1, 1, 8'h09, 2, wc, rdv, oev, csv, iw);
    access(22'h00FFF0, 1'b1, 0, 8'h00, 5, wc, rdv, oev, csv, iw);
    chk("abort_cfg_unchanged", {24'd0, rdv}, 32'h03);

    // rd and wr low together: sticky error, no write, timing unchanged
    access(22'h00FFF8, 1'b1, 2, 8'h0C, 6, wc, rdv, oev, csv, iw);
    chk("both_low_wait", wc, 32'd3);
    chk("both_low_oe", {31'd0, oev}, 32'd0);
    chk("bus_err_set", {31'd0, bus_if.bus_err}, 32'd1);
    access(22'h00FFF8, 1'b1, 0, 8'h00, 6, wc, rdv, oev, csv, iw);
    chk("both_low_no_write", {24'd0, rdv}, 32'h05);
    chk("bus_err_sticky", {31'd0, bus_if.bus_err}, 32'd1);

    // reset in the middle of a ROM wait
    @(posedge clk); #2;
    bus_if.address = 22'h000100;
    bus_if.mem_io  = 1'b1;
    bus_if.rd      = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #3;
    chk("pre_reset_wait", {31'd0, bus_if.pin_wait}, 32'd1);
    arst = 1'b0;
    #1;
    chk("mid_reset_wait", {31'd0, bus_if.pin_wait}, 32'd0);
    chk("mid_reset_bus_err", {31'd0, bus_if.bus_err}, 32'd0);
    bus_if.rd = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    arst = 1'b1;
    access(22'h00FFF8, 1'b1, 0, 8'h00, 6, wc, rdv, oev, csv, iw);
    chk("reset_rom_ws", {24'd0, rdv}, 32'h02);
    access(22'h00FFF9, 1'b1, 0, 8'h00, 6, wc, rdv, oev, csv, iw);
    chk("reset_bram_ws", {24'd0, rdv}, 32'h01);
    access(22'h000100, 1'b1, 0, 8'h00, 6, wc, rdv, oev, csv, iw);
    chk("reset_rom_wait", wc, 32'd2);
    chk("reset_bus_err_clear", {31'd0, bus_if.bus_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
